// File: rtl/riscv_m_pkg.sv
// Shared RV32M definitions: op encoding, sequencer states, decoded op control.
package riscv_m_pkg;

  localparam logic [6:0] OPC_RTYPE = 7'b0110011;
  localparam logic [6:0] F7_MULDIV = 7'b0000001;

  typedef enum logic [2:0] {
    MUL    = 3'b000,
    MULH   = 3'b001,
    MULHSU = 3'b010,
    MULHU  = 3'b011,
    DIV    = 3'b100,
    DIVU   = 3'b101,
    REM    = 3'b110,
    REMU   = 3'b111
  } m_op_e;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BUSY   = 2'd1,
    FINISH = 2'd2,
    DONE   = 2'd3
  } state_e;

  // Latched per-operation control: the op plus the sign of each operand
  // (already masked to zero where that operand is treated as unsigned).
  typedef struct packed {
    m_op_e op;
    logic  neg_a;
    logic  neg_b;
  } op_ctrl_t;

  function automatic logic is_div(m_op_e op);
    return op[2];
  endfunction

  function automatic logic a_signed(m_op_e op);
    return (op == MULH) || (op == MULHSU) || (op == DIV) || (op == REM);
  endfunction

  function automatic logic b_signed(m_op_e op);
    return (op == MULH) || (op == DIV) || (op == REM);
  endfunction

endpackage

// File: rtl/muldiv_datapath.sv
// Radix-2 iteration engine: shift-add multiply and restoring divide on
// unsigned magnitudes, one bit per step. Both engines run in lockstep; the
// sequencer picks whichever one the op needs.
module muldiv_datapath
  import riscv_m_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load,
  input  logic              step,
  input  logic [XLEN-1:0]   mag_a,
  input  logic [XLEN-1:0]   mag_b,
  output logic [2*XLEN-1:0] prod,
  output logic [XLEN-1:0]   quo,
  output logic [XLEN-1:0]   rem
);

  logic [XLEN-1:0] mcand;
  logic [XLEN-1:0] divisor;
  logic [XLEN:0]   rem_q;     // extra bit holds the subtract borrow

  logic [XLEN:0]   mul_sum;
  logic [XLEN+1:0] trial;
  logic [XLEN+1:0] diff;
  logic            borrow;

  // Add multiplicand into the high half when the multiplier LSB is set;
  // trial-subtract the divisor from the shifted partial remainder.
  always_comb begin
    mul_sum = {1'b0, prod[2*XLEN-1:XLEN]} + (prod[0] ? {1'b0, mcand} : '0);
    trial   = {rem_q, quo[XLEN-1]};
    diff    = trial - {2'b00, divisor};
    borrow  = diff[XLEN+1];
  end

  // Operand load, then one multiply bit and one quotient bit per step.
  always_ff @(posedge clk) begin
    if (reset) begin
      prod    <= '0;
      mcand   <= '0;
      quo     <= '0;
      rem_q   <= '0;
      divisor <= '0;
    end else if (load) begin
      prod    <= {{XLEN{1'b0}}, mag_a};
      mcand   <= mag_b;
      quo     <= mag_a;
      rem_q   <= '0;
      divisor <= mag_b;
    end else if (step) begin
      prod  <= {mul_sum, prod[XLEN-1:1]};
      rem_q <= borrow ? trial[XLEN:0] : diff[XLEN:0];
      quo   <= {quo[XLEN-2:0], ~borrow};
    end
  end

  assign rem = rem_q[XLEN-1:0];

endmodule

// File: rtl/muldiv_sequencer.sv
// RV32M multi-cycle controller: FSM, iteration counter, special-case fast
// path, sign fix-up and stall/done generation around muldiv_datapath.
module muldiv_sequencer
  import riscv_m_pkg::*;
#(
  parameter  int XLEN  = 32,
  localparam int CNT_W = $clog2(XLEN) + 1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] op_a,
  input  logic [XLEN-1:0] op_b,
  input  logic            kill,
  output logic            stall,
  output logic            done,
  output logic [XLEN-1:0] result
);

  state_e          state;
  logic [CNT_W-1:0] cnt;
  op_ctrl_t        ctrl;

  m_op_e           op_in;
  logic            sa_in, sb_in;
  logic [XLEN-1:0] mag_a, mag_b;
  logic            div_zero, div_ovf, fast;
  logic [XLEN-1:0] fast_res;
  logic            accept, load, step;

  logic [2*XLEN-1:0] prod, prod_fix;
  logic [XLEN-1:0]   quo, rem, quo_fix, rem_fix, fin_res;

  assign op_in = m_op_e'(funct3);

  // Decode the incoming op: operand signs, magnitudes and special cases.
  always_comb begin
    sa_in    = a_signed(op_in) & op_a[XLEN-1];
    sb_in    = b_signed(op_in) & op_b[XLEN-1];
    mag_a    = sa_in ? -op_a : op_a;
    mag_b    = sb_in ? -op_b : op_b;
    div_zero = is_div(op_in) && (op_b == '0);
    div_ovf  = ((op_in == DIV) || (op_in == REM)) &&
               (op_a == {1'b1, {(XLEN-1){1'b0}}}) && (op_b == '1);
    fast     = div_zero || div_ovf;
    fast_res = '0;
    if (div_zero)
      fast_res = ((op_in == DIV) || (op_in == DIVU)) ? '1 : op_a;
    else if (op_in == DIV)
      fast_res = op_a;   // most-negative / -1 overflows back to itself
  end

  assign accept = (state == IDLE) && start && !kill;
  assign load   = accept && !fast;
  assign step   = (state == BUSY) && !kill;
  assign stall  = accept || (state == BUSY) || (state == FINISH);

  muldiv_datapath #(.XLEN(XLEN)) u_dp (
    .clk   (clk),
    .reset (reset),
    .load  (load),
    .step  (step),
    .mag_a (mag_a),
    .mag_b (mag_b),
    .prod  (prod),
    .quo   (quo),
    .rem   (rem)
  );

  // Sign fix-up and word select for the FINISH cycle.
  always_comb begin
    prod_fix = (ctrl.neg_a ^ ctrl.neg_b) ? -prod : prod;
    quo_fix  = (ctrl.neg_a ^ ctrl.neg_b) ? -quo  : quo;
    rem_fix  = ctrl.neg_a ? -rem : rem;
    case (ctrl.op)
      MUL:                  fin_res = prod_fix[XLEN-1:0];
      MULH, MULHSU, MULHU:  fin_res = prod_fix[2*XLEN-1:XLEN];
      DIV, DIVU:            fin_res = quo_fix;
      default:              fin_res = rem_fix;
    endcase
  end

  // Control FSM; done and result are registered on entry to DONE.
  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      done   <= 1'b0;
      result <= '0;
      cnt    <= '0;
      ctrl   <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            ctrl <= '{op: op_in, neg_a: sa_in, neg_b: sb_in};
            if (fast) begin
              result <= fast_res;
              done   <= 1'b1;
              state  <= DONE;
            end else begin
              cnt   <= CNT_W'(XLEN);
              state <= BUSY;
            end
          end
        end
        BUSY: begin
          if (kill) begin
            state <= IDLE;
          end else begin
            cnt <= cnt - CNT_W'(1);
            if (cnt == CNT_W'(1)) state <= FINISH;
          end
        end
        FINISH: begin
          if (kill) begin
            state <= IDLE;
          end else begin
            result <= fin_res;
            done   <= 1'b1;
            state  <= DONE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Self-checking bench for muldiv_sequencer: directed corner cases, reset/kill
// aborts and randomized ops against an arithmetic reference model.
module tb_muldiv_sequencer;
  import riscv_m_pkg::*;

  logic        clk = 1'b0;
  logic        reset, start, kill;
  logic [2:0]  funct3;
  logic [31:0] op_a, op_b;
  logic        stall, done;
  logic [31:0] result;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  muldiv_sequencer #(.XLEN(32)) dut (
    .clk    (clk),
    .reset  (reset),
    .start  (start),
    .funct3 (funct3),
    .op_a   (op_a),
    .op_b   (op_b),
    .kill   (kill),
    .stall  (stall),
    .done   (done),
    .result (result)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // RISC-V M semantics from plain 64-bit arithmetic.
  function automatic logic [31:0] ref_m(logic [2:0] f, logic [31:0] a, logic [31:0] b);
    longint     sa, sb, ua, ub;
    logic [63:0] p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = longint'({32'b0, a});
    ub = longint'({32'b0, b});
    case (f)
      3'd0: begin p = ua * ub; return p[31:0];  end
      3'd1: begin p = sa * sb; return p[63:32]; end
      3'd2: begin p = sa * ub; return p[63:32]; end
      3'd3: begin p = ua * ub; return p[63:32]; end
      3'd4: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
        p = sa / sb; return p[31:0];
      end
      3'd5: begin
        if (b == 0) return 32'hFFFF_FFFF;
        p = ua / ub; return p[31:0];
      end
      3'd6: begin
        if (b == 0) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h0;
        p = sa % sb; return p[31:0];
      end
      default: begin
        if (b == 0) return a;
        p = ua % ub; return p[31:0];
      end
    endcase
  endfunction

  function automatic logic is_fast(logic [2:0] f, logic [31:0] a, logic [31:0] b);
    return (f[2] && b == 0) ||
           ((f == 3'd4 || f == 3'd6) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF);
  endfunction

  function automatic logic [31:0] rnd_operand();
    case ($urandom_range(0, 7))
      0: return 32'h0;
      1: return 32'h1;
      2: return 32'hFFFF_FFFF;
      3: return 32'h8000_0000;
      4: return 32'h7FFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  // Issue one op at the current negedge and follow it to done.
  // Leaves the bench at the negedge of the cycle after done.
  task automatic run_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                        input string tag);
    logic [31:0] exp;
    int          lat, exp_lat;
    logic        stall_ok;
    exp     = ref_m(f, a, b);
    exp_lat = is_fast(f, a, b) ? 1 : 34;
    start = 1'b1; funct3 = f; op_a = a; op_b = b;
    #1 chk({tag, ":stall_c0"}, {31'b0, stall}, 32'd1);
    @(negedge clk);
    start = 1'b0; funct3 = 3'($urandom); op_a = $urandom; op_b = $urandom;
    lat = 1; stall_ok = 1'b1;
    while (done !== 1'b1 && lat < 60) begin
      if (stall !== 1'b1) stall_ok = 1'b0;
      @(negedge clk);
      lat++;
    end
    chk({tag, ":latency"}, 32'(lat), 32'(exp_lat));
    chk({tag, ":stall_busy"}, {31'b0, stall_ok}, 32'd1);
    chk({tag, ":stall_done"}, {31'b0, stall}, 32'd0);
    chk({tag, ":result"}, result, exp);
    @(negedge clk);
    chk({tag, ":done_pulse"}, {31'b0, done}, 32'd0);
  endtask

  task automatic count_done(input int n, output int c);
    c = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (done === 1'b1) c++;
    end
  endtask

  logic [31:0] prev;
  int          nd;

  initial begin
    reset = 1'b1; start = 1'b0; kill = 1'b0;
    funct3 = 3'd0; op_a = '0; op_b = '0;
    repeat (3) @(negedge clk);
    chk("rst:done",   {31'b0, done},  32'd0);
    chk("rst:stall",  {31'b0, stall}, 32'd0);
    chk("rst:result", result, 32'd0);
    reset = 1'b0;
    @(negedge clk);

    run_op(MUL,    32'd7,         32'hFFFF_FFFD, "mul");
    run_op(MULH,   32'h8000_0000, 32'h8000_0000, "mulh");
    run_op(MULHU,  32'h8000_0000, 32'h8000_0000, "mulhu");
    run_op(MULHSU, 32'hFFFF_FFFF, 32'd2,         "mulhsu");
    run_op(DIVU,   32'd100,       32'd7,         "divu");
    run_op(REMU,   32'd100,       32'd7,         "remu");
    run_op(DIV,    32'hFFFF_FFF9, 32'd2,         "div_neg");
    run_op(REM,    32'hFFFF_FFF9, 32'd2,         "rem_neg");
    run_op(DIV,    32'd5,         32'd0,         "div_zero");

    // Reset in the 10th BUSY cycle discards the op.
    start = 1'b1; funct3 = MULHU; op_a = $urandom; op_b = $urandom;
    @(negedge clk); start = 1'b0;
    repeat (9) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("midrst:stall",  {31'b0, stall}, 32'd0);
    chk("midrst:done",   {31'b0, done},  32'd0);
    chk("midrst:result", result, 32'd0);
    count_done(40, nd);
    chk("midrst:no_done", 32'(nd), 32'd0);

    run_op(REMU, 32'd5,         32'd0,         "remu_zero");
    run_op(DIV,  32'h8000_0000, 32'hFFFF_FFFF, "div_ovf");
    run_op(REM,  32'h8000_0000, 32'hFFFF_FFFF, "rem_ovf");
    run_op(MUL,  32'd12345,     32'd678,       "mul_prev");
    prev = 32'd12345 * 32'd678;

    // Kill in BUSY cycle 5.
    start = 1'b1; funct3 = DIVU; op_a = $urandom; op_b = 32'd3;
    @(negedge clk); start = 1'b0;
    repeat (4) @(negedge clk);
    kill = 1'b1;
    @(negedge clk);
    kill = 1'b0;
    chk("kill_busy:stall",  {31'b0, stall}, 32'd0);
    chk("kill_busy:result", result, prev);
    count_done(40, nd);
    chk("kill_busy:no_done", 32'(nd), 32'd0);

    // Kill in FINISH (cycle 33).
    start = 1'b1; funct3 = MULH; op_a = $urandom; op_b = $urandom;
    @(negedge clk); start = 1'b0;
    repeat (32) @(negedge clk);
    kill = 1'b1;
    @(negedge clk);
    kill = 1'b0;
    chk("kill_fin:stall",  {31'b0, stall}, 32'd0);
    chk("kill_fin:result", result, prev);
    count_done(40, nd);
    chk("kill_fin:no_done", 32'(nd), 32'd0);

    // Kill alongside start in IDLE: not accepted.
    start = 1'b1; kill = 1'b1; funct3 = REM; op_a = 32'd9; op_b = 32'd4;
    #1 chk("kill_idle:stall", {31'b0, stall}, 32'd0);
    @(negedge clk); start = 1'b0; kill = 1'b0;
    count_done(40, nd);
    chk("kill_idle:no_done", 32'(nd), 32'd0);
    chk("kill_idle:result", result, prev);

    // Back-to-back ops, then randomized ops.
    run_op(DIVU, 32'hDEAD_BEEF, 32'd16, "b2b_a");
    run_op(REM,  32'hDEAD_BEEF, 32'hFFFF_FF00, "b2b_b");
    for (int i = 0; i < 30; i++)
      run_op(3'($urandom), rnd_operand(), rnd_operand(), $sformatf("rnd%0d", i));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
